imem_loader_ctrl: RTL and testbench
===================================

Name: imem_loader_ctrl

Overview:
- Sequences writes into the instruction memory from a byte-stream boot source (UART-style valid/ready) and shares the memory port between the loader and the fetch stage.
- While a load is in progress, the CPU is frozen and fetch is fed a NOP.
- On completion it pulses a CPU restart request, so execution begins again from PC 0 with the new program.
- Sits between the IF stage, the instruction memory and the boot receiver.

Parameters:
WORD_AW, 16, word-address width of instruction memory (65536 words; byte address bits [WORD_AW+1:2])
MAX_WORDS, 65536, largest accepted program length in words
NOP_INST, 32'hE1A00000, instruction returned to fetch while frozen (MOV R0,R0, cond AL)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a load; honoured only in IDLE
abort  in  1  cancel an in-progress load
rx_data  in  8  boot stream byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  byte accepted when rx_valid & rx_ready
fetch_addr  in  32  byte PC from IF stage
fetch_inst  out  32  instruction to IF stage
mem_addr  out  32  byte address to instruction memory
mem_rdata  in  32  combinational read data from instruction memory
mem_we  out  1  word write strobe
mem_wdata  out  32  word write data
cpu_freeze  out  1  stall the whole pipeline
cpu_rst_req  out  1  one-cycle pipeline/PC reset request
load_done  out  1  one-cycle completion pulse
load_err  out  1  sticky error flag, cleared by the next accepted start
words_loaded  out  WORD_AW+1  words written in the current/last load

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs listed are 0. Internal len, word_cnt, byte_idx and shift register are all 0.
  - Memory contents are untouched.
- States: IDLE, LEN_LO, LEN_HI, LOAD, WRITE, DONE.
- IDLE:
  - cpu_freeze=0, rx_ready=0.
  - mem_addr=fetch_addr; fetch_inst=mem_rdata (combinational pass-through).
  - start=1 -> LEN_LO; clear load_err, words_loaded and word_cnt.
- LEN_LO / LEN_HI:
  - rx_ready=1.
  - Each accepted byte forms len, little-endian (low byte first).
  - On the LEN_HI accept:
    - len==0 -> DONE.
    - len>MAX_WORDS -> IDLE with load_err=1.
    - otherwise -> LOAD.
- LOAD:
  - rx_ready=1.
  - Each accepted byte is shifted in little-endian (first byte = bits[7:0]) and byte_idx increments.
  - On the 4th byte, register mem_wdata, set byte_idx=0 and go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, rx_ready=0, mem_addr={word_cnt,2'b00}.
  - Next cycle: word_cnt and words_loaded increment.
  - If word_cnt+1==len -> DONE, else -> LOAD.
- DONE (one cycle): load_done=1 and cpu_rst_req=1, then -> IDLE. cpu_freeze stays 1 during DONE.
- Freeze and fetch behaviour:
  - cpu_freeze=1 in every state except IDLE.
  - While frozen, fetch_inst=NOP_INST, and mem_addr is driven by the loader ({word_cnt,2'b00}) regardless of fetch_addr.
  - mem_we is never asserted outside WRITE.
- Throughput: maximum is 1 byte/cycle in LOAD. Each word takes 4 accept cycles plus 1 WRITE cycle.
- rx_valid low stalls the current state indefinitely. There is no timeout.
- start outside IDLE is ignored.
- abort:
  - Takes priority over start, the rx handshake and state transitions.
  - In any non-IDLE state: -> IDLE next cycle, load_err=1, no write and no cpu_rst_req.
  - A partial word is discarded. Words already written remain.
  - abort in IDLE has no effect.
- A simultaneous accepted 4th byte and abort: abort wins and the word is not written.
- Reset mid-load: immediate return to IDLE, freeze released, no cpu_rst_req.
- Wrap-around: word_cnt can never exceed MAX_WORDS-1 because len is bounded at LEN_HI.

Decomposition:
- Shared package/header holds:
  - State encodings (3-bit localparams).
  - NOP_INST.
  - The condition-code constant AL=4'b1110, shared with the decode/condition-check logic.
- One sub-module, imem_word_packer: byte_idx counter plus 32-bit little-endian shift register, with clear and word_valid outputs.
- The FSM and the port mux stay in the top.

Test Plan:
1. Reset, then fetch_addr=32'h8 -> fetch_inst==mem_rdata, cpu_freeze=0, all strobes 0.
2. start, send 02 00 then bytes 14 00 A0 E3, 05 10 A0 E3:
   - mem_we pulses twice: addr 0x0 data 32'hE3A00014, then addr 0x4 data 32'hE3A01005.
   - load_done and cpu_rst_req pulse once.
   - words_loaded=2.
   - fetch_inst==NOP_INST throughout the load.
3. start, send length 00 00 -> DONE next cycle; no mem_we; load_done=1; load_err=0.
4. With MAX_WORDS=4: start, send length 05 00 -> IDLE, load_err=1, no mem_we, cpu_freeze drops.
5. Load len=3; after 1 word plus 2 bytes assert abort -> one write only, load_err=1, no cpu_rst_req, freeze released next cycle.
6. rx_valid toggled randomly during a 4-word load -> the same 4 words are written. Separately, an rst pulse mid-LOAD forces all outputs to 0 asynchronously.

Source files
------------

// File: rtl/imem_loader_ctrl_pkg.sv
// rtl/imem_loader_ctrl_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_LOAD   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Condition code "always", shared with the decode/condition-check logic
    localparam logic [3:0] COND_AL = 4'b1110;

    // MOV R0,R0 with cond AL: what fetch sees while the CPU is frozen
    localparam logic [31:0] DEFAULT_NOP_INST = {COND_AL, 28'h1A00000};

    // Word index to byte address
    function automatic logic [31:0] word_to_byte_addr(input logic [29:0] word_idx);
        return {word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_ctrl_if.sv
// rtl/imem_loader_ctrl_if.sv - boot stream, fetch and instruction memory port bundle
interface imem_loader_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_inst;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_wdata;

    modport slave (
        input  rx_data, rx_valid, fetch_addr, mem_rdata,
        output rx_ready, fetch_inst, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output rx_data, rx_valid, fetch_addr, mem_rdata,
        input  rx_ready, fetch_inst, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_loader_ctrl_word_packer.sv
// rtl/imem_loader_ctrl_word_packer.sv - little-endian byte to word assembler
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx;
    logic [23:0] shift_q;

    // The 4th byte completes the word combinationally so the loader can register it directly
    assign word_valid = byte_valid && (byte_idx == 2'd3);
    assign word       = {byte_data, shift_q};

    // Shift in from the top so the first byte ends up in bits [7:0]; index wraps after 4 bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= 2'd0;
            shift_q  <= 24'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            shift_q  <= 24'd0;
        end else if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            shift_q  <= {byte_data, shift_q[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader_ctrl.sv
// rtl/imem_loader_ctrl.sv - boot loader sequencer and instruction memory port mux
module imem_loader_ctrl
    import imem_loader_ctrl_pkg::*;
#(
    parameter int          WORD_AW   = 16,
    parameter int          MAX_WORDS = 65536,
    parameter logic [31:0] NOP_INST  = DEFAULT_NOP_INST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    imem_loader_ctrl_if.slave  bus,
    output logic               cpu_freeze,
    output logic               cpu_rst_req,
    output logic               load_done,
    output logic               load_err,
    output logic [WORD_AW:0]   words_loaded
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    state_t            state;
    logic [16:0]       len;
    logic [WORD_AW:0]  word_cnt;
    logic              rx_ready_r;
    logic              mem_we_r;
    logic [31:0]       mem_wdata_r;
    logic              rx_fire;
    logic [16:0]       len_full;
    logic [31:0]       cnt_next;
    logic              pk_clear;
    logic              pk_valid;
    logic              pk_word_valid;
    logic [31:0]       pk_word;
    logic [31:0]       loader_addr;
    logic [31:0]       mem_addr_c;
    logic [31:0]       fetch_inst_c;

    assign rx_fire     = bus.rx_valid && rx_ready_r;
    assign len_full    = {1'b0, bus.rx_data, len[7:0]};
    assign cnt_next    = 32'(word_cnt) + 32'd1;
    assign loader_addr = word_to_byte_addr(30'(word_cnt[WORD_AW-1:0]));

    // Abort drops any partial word; bytes only enter the packer while loading and not aborting
    assign pk_clear = abort || ((state == ST_IDLE) && start);
    assign pk_valid = (state == ST_LOAD) && rx_fire && !abort;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_data  (bus.rx_data),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    // Loader sequencer; all strobes and handshakes are registered alongside the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            len         <= 17'd0;
            word_cnt    <= '0;
            rx_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 32'd0;
            cpu_freeze  <= 1'b0;
            cpu_rst_req <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            mem_we_r    <= 1'b0;
            load_done   <= 1'b0;
            cpu_rst_req <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state      <= ST_IDLE;
                load_err   <= 1'b1;
                cpu_freeze <= 1'b0;
                rx_ready_r <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state      <= ST_LEN_LO;
                            load_err   <= 1'b0;
                            word_cnt   <= '0;
                            len        <= 17'd0;
                            cpu_freeze <= 1'b1;
                            rx_ready_r <= 1'b1;
                        end
                    end
                    ST_LEN_LO: begin
                        if (rx_fire) begin
                            len[7:0] <= bus.rx_data;
                            state    <= ST_LEN_HI;
                        end
                    end
                    ST_LEN_HI: begin
                        if (rx_fire) begin
                            len <= len_full;
                            if (len_full == 17'd0) begin
                                state       <= ST_DONE;
                                rx_ready_r  <= 1'b0;
                                load_done   <= 1'b1;
                                cpu_rst_req <= 1'b1;
                            end else if ({15'd0, len_full} > MAX_W) begin
                                state      <= ST_IDLE;
                                load_err   <= 1'b1;
                                cpu_freeze <= 1'b0;
                                rx_ready_r <= 1'b0;
                            end else begin
                                state <= ST_LOAD;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (pk_word_valid) begin
                            mem_wdata_r <= pk_word;
                            mem_we_r    <= 1'b1;
                            rx_ready_r  <= 1'b0;
                            state       <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        word_cnt <= word_cnt + {{WORD_AW{1'b0}}, 1'b1};
                        if (cnt_next == {15'd0, len}) begin
                            state       <= ST_DONE;
                            load_done   <= 1'b1;
                            cpu_rst_req <= 1'b1;
                        end else begin
                            state      <= ST_LOAD;
                            rx_ready_r <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state      <= ST_IDLE;
                        cpu_freeze <= 1'b0;
                    end
                    default: begin
                        state      <= ST_IDLE;
                        cpu_freeze <= 1'b0;
                        rx_ready_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Fetch owns the memory port in IDLE; otherwise the loader drives it and fetch sees a NOP
    always_comb begin
        mem_addr_c   = 32'd0;
        fetch_inst_c = 32'd0;
        if (rst) begin
            if (state == ST_IDLE) begin
                mem_addr_c   = bus.fetch_addr;
                fetch_inst_c = bus.mem_rdata;
            end else begin
                mem_addr_c   = loader_addr;
                fetch_inst_c = NOP_INST;
            end
        end
    end

    assign bus.rx_ready   = rx_ready_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.fetch_inst = fetch_inst_c;
    assign words_loaded   = word_cnt;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb/tb_imem_loader_ctrl.sv - scoreboard bench for imem_loader_ctrl
module tb_imem_loader_ctrl;

    localparam int          MAXW = 4;
    localparam logic [31:0] NOP  = 32'hE1A00000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        cpu_freeze, cpu_rst_req, load_done, load_err;
    logic [16:0] words_loaded;
    logic        rand_fetch = 1'b0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    wr_t         exp_wr[$];
    int          exp_done[$];
    int          checks = 0;
    int          failures = 0;

    imem_loader_ctrl_if ifc();

    imem_loader_ctrl #(.WORD_AW(16), .MAX_WORDS(MAXW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .bus          (ifc),
        .cpu_freeze   (cpu_freeze),
        .cpu_rst_req  (cpu_rst_req),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    assign ifc.mem_rdata = mem[ifc.mem_addr[9:2]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event at %0t", nm, $time);
    endtask

    // Memory image: both copies start identical; the DUT writes only the real one
    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        forever begin
            @(posedge clk);
            if (rst && ifc.mem_we) mem[ifc.mem_addr[9:2]] = ifc.mem_wdata;
        end
    end

    // Random aligned fetch PC
    initial begin
        forever begin
            @(negedge clk);
            if (rand_fetch) ifc.fetch_addr = {22'd0, 8'($urandom), 2'b00};
        end
    end

    // Monitor: pops expected writes and completions whenever the DUT presents them
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) continue;
            if (ifc.mem_we) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", ifc.mem_addr, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("write_addr", ifc.mem_addr, e.addr);
                    chk("write_data", ifc.mem_wdata, e.data);
                end
            end
            if (load_done || cpu_rst_req) begin
                chk("rst_req_with_done", 32'(cpu_rst_req), 32'(load_done));
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 32'(words_loaded), 32'hFFFF_FFFF);
                end else begin
                    int w;
                    w = exp_done.pop_front();
                    chk("done_words", 32'(words_loaded), 32'(w));
                    chk("done_err", 32'(load_err), 32'd0);
                end
            end
            if (cpu_freeze) begin
                chk("frozen_nop", ifc.fetch_inst, NOP);
            end else begin
                chk("idle_mem_addr", ifc.mem_addr, ifc.fetch_addr);
                chk("idle_fetch_inst", ifc.fetch_inst, ref_mem[ifc.fetch_addr[9:2]]);
                chk("idle_strobes", {30'd0, ifc.mem_we, ifc.rx_ready}, 32'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_freeze"}, 32'(cpu_freeze), 32'd0);
        chk({tag, "_strobes"}, {28'd0, cpu_rst_req, load_done, ifc.mem_we, ifc.rx_ready}, 32'd0);
        chk({tag, "_err"}, 32'(load_err), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
        chk({tag, "_mem_addr"}, ifc.mem_addr, 32'd0);
        chk({tag, "_fetch_inst"}, ifc.fetch_inst, 32'd0);
        chk({tag, "_wdata"}, ifc.mem_wdata, 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one byte, optionally with random idle cycles (which also try a stray start)
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            ifc.rx_valid = 1'b0;
            start = 1'b0;
            if (n > 200) begin
                fail_now("send_byte");
                return;
            end
            n++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 3) == 0) start = 1'b1;
                continue;
            end
            ifc.rx_data = b;
            ifc.rx_valid = 1'b1;
            if (ifc.rx_ready) begin
                chk("freeze_on_accept", 32'(cpu_freeze), 32'd1);
                @(posedge clk);
                return;
            end
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            ifc.rx_valid = 1'b0;
            start = 1'b0;
            #1;
            if (!cpu_freeze) return;
        end
        fail_now("wait_idle");
    endtask

    function automatic logic [31:0] pack(input logic [7:0] d[$], input int w);
        return 32'(d[4*w]) + (32'(d[4*w+1]) << 8) + (32'(d[4*w+2]) << 16) + (32'(d[4*w+3]) << 24);
    endfunction

    // Full load of nw words (length header first); the model is the little-endian word list
    task automatic do_load(input int nw, input logic [7:0] d[$], input bit gaps);
        logic [15:0] l;
        l = 16'(nw);
        pulse_start();
        send_byte(l[7:0], gaps);
        if (nw == 0) exp_done.push_back(0);
        send_byte(l[15:8], gaps);
        if (nw == 0 || nw > MAXW) begin
            wait_idle();
            chk("hdr_err", 32'(load_err), (nw > MAXW) ? 32'd1 : 32'd0);
            chk("hdr_words", 32'(words_loaded), 32'd0);
            return;
        end
        for (int w = 0; w < nw; w++) begin
            wr_t e;
            e.addr = 32'(w * 4);
            e.data = pack(d, w);
            exp_wr.push_back(e);
            ref_mem[w] = e.data;
            if (w == nw - 1) exp_done.push_back(nw);
            for (int b = 0; b < 4; b++) send_byte(d[4*w+b], gaps);
        end
        wait_idle();
        chk("load_err_clear", 32'(load_err), 32'd0);
        chk("load_words", 32'(words_loaded), 32'(nw));
    endtask

    task automatic rand_bytes(input int n, output logic [7:0] d[$]);
        d = {};
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] d[$];
        ifc.rx_valid = 1'b0;
        ifc.rx_data = 8'd0;
        ifc.fetch_addr = 32'h8;

        // Reset state
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("post_reset_fetch", ifc.fetch_inst, ref_mem[2]);
        chk("post_reset_freeze", 32'(cpu_freeze), 32'd0);
        rand_fetch = 1'b1;

        // Two known words
        d = {8'h14, 8'h00, 8'hA0, 8'hE3, 8'h05, 8'h10, 8'hA0, 8'hE3};
        do_load(2, d, 1'b0);

        // Zero length, then oversize lengths
        d = {};
        do_load(0, d, 1'b0);
        do_load(5, d, 1'b0);
        do_load(256, d, 1'b1);

        // Abort after one word plus two bytes
        rand_bytes(12, d);
        pulse_start();
        send_byte(8'd3, 1'b0);
        send_byte(8'd0, 1'b0);
        begin
            wr_t e;
            e.addr = 32'd0;
            e.data = pack(d, 0);
            exp_wr.push_back(e);
            ref_mem[0] = e.data;
        end
        for (int b = 0; b < 6; b++) send_byte(d[b], 1'b0);
        @(negedge clk);
        ifc.rx_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_freeze", 32'(cpu_freeze), 32'd0);
        chk("abort_err", 32'(load_err), 32'd1);
        chk("abort_words", 32'(words_loaded), 32'd1);

        // Abort in IDLE is ignored; err stays until the next start
        do_load(1, d, 1'b0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("idle_abort_err", 32'(load_err), 32'd0);
        chk("idle_abort_freeze", 32'(cpu_freeze), 32'd0);

        // Abort together with the 4th byte of the second word
        rand_bytes(8, d);
        pulse_start();
        send_byte(8'd2, 1'b0);
        send_byte(8'd0, 1'b0);
        begin
            wr_t e;
            e.addr = 32'd0;
            e.data = pack(d, 0);
            exp_wr.push_back(e);
            ref_mem[0] = e.data;
        end
        for (int b = 0; b < 7; b++) send_byte(d[b], 1'b0);
        @(negedge clk);
        ifc.rx_data = d[7];
        ifc.rx_valid = 1'b1;
        abort = 1'b1;
        chk("abort4_ready", 32'(ifc.rx_ready), 32'd1);
        @(negedge clk);
        abort = 1'b0;
        ifc.rx_valid = 1'b0;
        #1;
        chk("abort4_err", 32'(load_err), 32'd1);
        chk("abort4_words", 32'(words_loaded), 32'd1);
        repeat (3) @(negedge clk);

        // Random 4-word load with rx_valid gaps, then random lengths
        rand_bytes(16, d);
        do_load(4, d, 1'b1);
        for (int t = 0; t < 6; t++) begin
            int nw;
            nw = $urandom_range(1, MAXW);
            rand_bytes(4 * nw, d);
            do_load(nw, d, 1'b1);
        end

        // Asynchronous reset in the middle of a load
        rand_bytes(12, d);
        pulse_start();
        send_byte(8'd3, 1'b0);
        send_byte(8'd0, 1'b0);
        begin
            wr_t e;
            e.addr = 32'd0;
            e.data = pack(d, 0);
            exp_wr.push_back(e);
            ref_mem[0] = e.data;
        end
        for (int b = 0; b < 6; b++) send_byte(d[b], 1'b0);
        @(negedge clk);
        ifc.rx_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midload_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        #2;
        chk("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
        chk("exp_done_drained", 32'(exp_done.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
